pseudo_vt52_engine: RTL and testbench

PSEUDO_VT52_ENGINE -- requirements
Module: pseudo_vt52_engine

---
 rtl/pseudo_vt52_engine_if.sv | 31 +++
 rtl/pseudo_vt52_engine.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_pseudo_vt52_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pseudo_vt52_engine_if.sv
// Character-input handshake and screen-memory write port of the VT52-style
// terminal engine. The engine is the slave: it consumes characters and
// drives the memory write strobe; the character source / memory side is the master.
interface pseudo_vt52_engine_if #(
    parameter int AW = 11
);
    logic          in_valid;
    logic [6:0]    in_data;
    logic          in_ready;
    logic [AW-1:0] mem_addr;
    logic [6:0]    mem_wdata;
    logic          mem_we;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_addr,
        output mem_wdata,
        output mem_we
    );
endinterface

// File: rtl/pseudo_vt52_engine.sv
// VT52-style character engine: decodes printable characters, control codes
// and ESC sequences, keeps the cursor and a circular screen (topline), and
// writes character cells / clears lines into an external screen memory.
module pseudo_vt52_engine #(
    parameter int COLS     = 80,
    parameter int ROWS     = 24,
    parameter int AW       = 11,
    parameter int AUTOWRAP = 0,
    parameter int TABW     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    pseudo_vt52_engine_if.slave  bus,
    output logic [6:0]           cur_x,
    output logic [4:0]           cur_y,
    output logic [4:0]           topline,
    output logic                 bell
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ESC,
        S_CADY,
        S_CADX,
        S_CLRLINE,
        S_CLRSCR
    } state_t;

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    localparam logic [7:0] TAB_MASK = 8'(TABW - 1);

    // Next physical row, wrapping at ROWS (not at 32).
    function automatic logic [4:0] row_inc(input logic [4:0] r);
        return (r == LAST_ROW) ? 5'd0 : r + 5'd1;
    endfunction

    // Previous physical row, wrapping at ROWS.
    function automatic logic [4:0] row_dec(input logic [4:0] r);
        return (r == 5'd0) ? LAST_ROW : r - 5'd1;
    endfunction

    // Logical row to physical memory row: (row + top) mod ROWS.
    function automatic logic [4:0] phys_row(input logic [4:0] r, input logic [4:0] t);
        logic [5:0] s;
        s = {1'b0, r} + {1'b0, t};
        return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
    endfunction

    // Linear memory address of a cell.
    function automatic logic [AW-1:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    // Printable range 040..176; 0177 is deliberately excluded.
    function automatic logic is_print(input logic [6:0] c);
        return (c >= 7'o040) && (c <= 7'o176);
    endfunction

    // Graph mode remaps the upper printable range down by 0137 (mod 128).
    function automatic logic [6:0] glyph(input logic [6:0] c, input logic g);
        return (g && (c >= 7'o136)) ? (c - 7'o137) : c;
    endfunction

    state_t          state_r, state_s;
    logic [6:0]      x_r, x_s;
    logic [4:0]      row_r, row_s;
    logic [4:0]      top_r, top_s;
    logic [4:0]      cy_r, cy_s;
    logic            graph_r, graph_s;
    logic            bell_r, bell_s;
    logic [4:0]      clr_row_r, clr_row_s;
    logic [6:0]      clr_col_r, clr_col_s;
    logic            clr_scr_r, clr_scr_s;
    logic            we_r, we_s;
    logic [AW-1:0]   addr_r, addr_s;
    logic [6:0]      wdata_r, wdata_s;

    logic            ready_s;
    logic            accept_s;
    logic [6:0]      ch_s;
    logic [4:0]      here_s;
    logic [7:0]      tab_s;
    logic [6:0]      off_s;
    logic [4:0]      nrow_s;
    logic [4:0]      lf_row_s;
    logic            lf_scroll_s;

    // Next-state, cursor, scroll and memory-write decode.
    always_comb begin
        state_s     = state_r;
        x_s         = x_r;
        row_s       = row_r;
        top_s       = top_r;
        graph_s     = graph_r;
        bell_s      = bell_r;
        clr_row_s   = clr_row_r;
        clr_col_s   = clr_col_r;
        clr_scr_s   = clr_scr_r;
        we_s        = 1'b0;
        addr_s      = addr_r;
        wdata_s     = 7'd0;
        ch_s        = bus.in_data;
        here_s      = phys_row(row_r, top_r);
        tab_s       = ({1'b0, x_r} | TAB_MASK) + 8'd1;
        off_s       = ch_s - 7'o040;
        nrow_s      = row_inc(clr_row_r);
        lf_row_s    = (row_r != LAST_ROW) ? row_r + 5'd1 : row_r;
        lf_scroll_s = (row_r == LAST_ROW);

        case (state_r)
            S_IDLE, S_ESC, S_CADY, S_CADX: ready_s = 1'b1;
            default:                       ready_s = 1'b0;
        endcase
        accept_s = bus.in_valid & ready_s;

        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    if (is_print(ch_s)) begin
                        we_s    = 1'b1;
                        addr_s  = cell_addr(here_s, x_r);
                        wdata_s = glyph(ch_s, graph_r);
                        if (x_r != LAST_COL) begin
                            x_s = x_r + 7'd1;
                        end else if (AUTOWRAP != 0) begin
                            // Wrap: column 0 plus the line-feed rule.
                            x_s   = 7'd0;
                            row_s = lf_row_s;
                            if (lf_scroll_s) begin
                                top_s     = row_inc(top_r);
                                clr_row_s = top_r;
                                clr_col_s = 7'd0;
                                clr_scr_s = 1'b0;
                                state_s   = S_CLRLINE;
                            end else begin
                                state_s = S_IDLE;
                            end
                        end else begin
                            x_s = x_r;
                        end
                    end else begin
                        case (ch_s)
                            7'o007: bell_s = ~bell_r;
                            7'o010: x_s = (x_r == 7'd0) ? 7'd0 : x_r - 7'd1;
                            7'o011: x_s = (tab_s >= 8'(COLS)) ? LAST_COL : tab_s[6:0];
                            7'o012: begin
                                // At the bottom the screen scrolls: the old top
                                // physical row becomes the new (blank) bottom line.
                                row_s = lf_row_s;
                                if (lf_scroll_s) begin
                                    top_s     = row_inc(top_r);
                                    clr_row_s = top_r;
                                    clr_col_s = 7'd0;
                                    clr_scr_s = 1'b0;
                                    state_s   = S_CLRLINE;
                                end else begin
                                    state_s = S_IDLE;
                                end
                            end
                            7'o015: x_s = 7'd0;
                            7'o033: state_s = S_ESC;
                            default: state_s = S_IDLE;
                        endcase
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end

            S_ESC: begin
                if (accept_s) begin
                    state_s = S_IDLE;
                    case (ch_s)
                        7'h41: row_s   = (row_r == 5'd0) ? 5'd0 : row_r - 5'd1;
                        7'h42: row_s   = (row_r == LAST_ROW) ? LAST_ROW : row_r + 5'd1;
                        7'h43: x_s     = (x_r == LAST_COL) ? LAST_COL : x_r + 7'd1;
                        7'h44: x_s     = (x_r == 7'd0) ? 7'd0 : x_r - 7'd1;
                        7'h46: graph_s = 1'b1;
                        7'h47: graph_s = 1'b0;
                        7'h48: begin
                            row_s = 5'd0;
                            x_s   = 7'd0;
                        end
                        7'h49: begin
                            // Reverse index at the top scrolls the screen down.
                            if (row_r == 5'd0) begin
                                top_s     = row_dec(top_r);
                                clr_row_s = row_dec(top_r);
                                clr_col_s = 7'd0;
                                clr_scr_s = 1'b0;
                                state_s   = S_CLRLINE;
                            end else begin
                                row_s = row_r - 5'd1;
                            end
                        end
                        7'h4A: begin
                            clr_row_s = here_s;
                            clr_col_s = x_r;
                            clr_scr_s = 1'b1;
                            state_s   = S_CLRLINE;
                        end
                        7'h4B: begin
                            clr_row_s = here_s;
                            clr_col_s = x_r;
                            clr_scr_s = 1'b0;
                            state_s   = S_CLRLINE;
                        end
                        7'h59: state_s = S_CADY;
                        default: state_s = S_IDLE;
                    endcase
                end else begin
                    state_s = S_ESC;
                end
            end

            S_CADY: begin
                if (accept_s) begin
                    if ((ch_s >= 7'o040) && (off_s < 7'(ROWS))) begin
                        row_s = off_s[4:0];
                    end else begin
                        row_s = row_r;
                    end
                    state_s = S_CADX;
                end else begin
                    state_s = S_CADY;
                end
            end

            S_CADX: begin
                if (accept_s) begin
                    if (ch_s >= 7'o040) begin
                        x_s = (off_s > LAST_COL) ? LAST_COL : off_s;
                    end else begin
                        x_s = x_r;
                    end
                    state_s = S_IDLE;
                end else begin
                    state_s = S_CADX;
                end
            end

            S_CLRLINE, S_CLRSCR: begin
                we_s    = 1'b1;
                addr_s  = cell_addr(clr_row_r, clr_col_r);
                wdata_s = 7'd0;
                if (clr_col_r != LAST_COL) begin
                    clr_col_s = clr_col_r + 7'd1;
                end else if ((state_r == S_CLRLINE) && !clr_scr_r) begin
                    state_s = S_IDLE;
                end else if (nrow_s == top_r) begin
                    // Wrapped round to the top of the screen: every row below is clear.
                    state_s = S_IDLE;
                end else begin
                    state_s   = S_CLRSCR;
                    clr_row_s = nrow_s;
                    clr_col_s = 7'd0;
                end
            end

            default: state_s = S_IDLE;
        endcase

        cy_s = phys_row(row_s, top_s);
    end

    // State and output registers; reset restarts a full-screen clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= S_CLRSCR;
            x_r       <= 7'd0;
            row_r     <= 5'd0;
            top_r     <= 5'd0;
            cy_r      <= 5'd0;
            graph_r   <= 1'b0;
            bell_r    <= 1'b0;
            clr_row_r <= 5'd0;
            clr_col_r <= 7'd0;
            clr_scr_r <= 1'b0;
            we_r      <= 1'b0;
            addr_r    <= {AW{1'b0}};
            wdata_r   <= 7'd0;
        end else begin
            state_r   <= state_s;
            x_r       <= x_s;
            row_r     <= row_s;
            top_r     <= top_s;
            cy_r      <= cy_s;
            graph_r   <= graph_s;
            bell_r    <= bell_s;
            clr_row_r <= clr_row_s;
            clr_col_r <= clr_col_s;
            clr_scr_r <= clr_scr_s;
            we_r      <= we_s;
            addr_r    <= addr_s;
            wdata_r   <= wdata_s;
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.mem_we    = we_r;
    assign bus.mem_addr  = addr_r;
    assign bus.mem_wdata = wdata_r;
    assign cur_x         = x_r;
    assign cur_y         = cy_r;
    assign topline       = top_r;
    assign bell          = bell_r;

endmodule

// File: tb/tb_pseudo_vt52_engine.sv
// Bench for pseudo_vt52_engine: a table of single-character vectors with
// hand-computed results, plus directed sequences for scrolling, clears,
// autowrap (second instance) and reset during a clear.
module tb_pseudo_vt52_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pseudo_vt52_engine_if #(.AW(11)) bus0 ();
    pseudo_vt52_engine_if #(.AW(11)) bus1 ();

    logic [6:0] x0, x1;
    logic [4:0] y0, y1, t0, t1;
    logic       b0, b1;

    pseudo_vt52_engine #(.COLS(80), .ROWS(24), .AW(11), .AUTOWRAP(0), .TABW(8)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0),
        .cur_x(x0), .cur_y(y0), .topline(t0), .bell(b0)
    );

    pseudo_vt52_engine #(.COLS(80), .ROWS(24), .AW(11), .AUTOWRAP(1), .TABW(8)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1),
        .cur_x(x1), .cur_y(y1), .topline(t1), .bell(b1)
    );

    int checks = 0;
    int errors = 0;

    // Writes seen on instance 0, captured mid-cycle.
    logic [17:0] wq[$];
    always @(negedge clk) begin
        if (bus0.mem_we === 1'b1) wq.push_back({bus0.mem_addr, bus0.mem_wdata});
    end

    typedef struct {
        logic [6:0]  ch;
        logic        we;
        logic [10:0] addr;
        logic [6:0]  data;
        logic [6:0]  x;
        logic [4:0]  y;
        logic        bell;
    } vec_t;

    vec_t v[$];
    logic eb;

    function automatic void nv(input logic [6:0] c, input int px, input int py);
        v.push_back('{c, 1'b0, 11'd0, 7'd0, 7'(px), 5'(py), eb});
    endfunction

    function automatic void wv(input logic [6:0] c, input int a, input logic [6:0] d,
                               input int px, input int py);
        v.push_back('{c, 1'b1, 11'(a), d, 7'(px), 5'(py), eb});
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        return (w == 0) ? bus0.in_ready : bus1.in_ready;
    endfunction

    // Wait for in_ready, let the monitor catch the final write, then re-align.
    task automatic wait_idle(input int w, input int budget, input string name);
        int n = 0;
        while (rdy(w) !== 1'b1 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, rdy(w), 1);
        @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic send(input int w, input logic [6:0] c);
        int n = 0;
        while (rdy(w) !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (rdy(w) !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_ready: got %0d, expected 1", rdy(w));
        end
        if (w == 0) begin
            bus0.in_valid = 1'b1;
            bus0.in_data  = c;
        end else begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = c;
        end
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    task automatic check_writes(input string name, input int first, input int count);
        int bad = 0;
        logic [17:0] e;
        chk({name, "_count"}, wq.size(), count);
        for (int i = 0; i < wq.size(); i++) begin
            e = {11'(first + i), 7'd0};
            if (wq[i] !== e) bad++;
        end
        chk({name, "_cells"}, bad, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_we"},    bus0.mem_we, 0);
        chk({tag, "_x"},     x0, 0);
        chk({tag, "_y"},     y0, 0);
        chk({tag, "_top"},   t0, 0);
        chk({tag, "_bell"},  b0, 0);
        chk({tag, "_ready"}, bus0.in_ready, 0);
        wq.delete();
        reset = 1'b0;
        wait_idle(0, 3000, {tag, "_idle"});
        check_writes({tag, "_clear"}, 0, 1920);
    endtask

    initial begin
        reset = 1'b1;
        bus0.in_valid = 1'b0;
        bus0.in_data  = 7'd0;
        bus1.in_valid = 1'b0;
        bus1.in_data  = 7'd0;

        eb = 1'b0;
        wv(7'o101, 0, 7'o101, 1, 0);
        wv(7'o102, 1, 7'o102, 2, 0);
        nv(7'o010, 1, 0);
        nv(7'o011, 8, 0);
        nv(7'o011, 16, 0);
        eb = 1'b1;
        nv(7'o007, 16, 0);
        nv(7'o015, 0, 0);
        nv(7'o012, 0, 1);
        nv(7'o033, 0, 1);  nv(7'o106, 0, 1);
        wv(7'o141, 80, 7'o002, 1, 1);
        wv(7'o136, 81, 7'o177, 2, 1);
        wv(7'o135, 82, 7'o135, 3, 1);
        nv(7'o033, 3, 1);  nv(7'o107, 3, 1);
        wv(7'o141, 83, 7'o141, 4, 1);
        nv(7'o177, 4, 1);
        nv(7'o033, 4, 1);  nv(7'o103, 5, 1);
        nv(7'o033, 5, 1);  nv(7'o104, 4, 1);
        nv(7'o033, 4, 1);  nv(7'o102, 4, 2);
        nv(7'o033, 4, 2);  nv(7'o101, 4, 1);
        nv(7'o033, 4, 1);  nv(7'o131, 4, 1);  nv(7'o047, 4, 7);  nv(7'o157, 79, 7);
        wv(7'o130, 639, 7'o130, 79, 7);
        wv(7'o132, 639, 7'o132, 79, 7);
        nv(7'o033, 79, 7); nv(7'o131, 79, 7); nv(7'o040, 79, 0); nv(7'o153, 75, 0);
        nv(7'o033, 75, 0); nv(7'o131, 75, 0); nv(7'o177, 75, 0); nv(7'o037, 75, 0);
        nv(7'o033, 75, 0); nv(7'o131, 75, 0); nv(7'o040, 75, 0); nv(7'o177, 79, 0);
        nv(7'o033, 79, 0); nv(7'o131, 79, 0); nv(7'o040, 79, 0); nv(7'o153, 75, 0);
        nv(7'o011, 79, 0);
        nv(7'o033, 79, 0); nv(7'o110, 0, 0);
        nv(7'o033, 0, 0);  nv(7'o101, 0, 0);
        nv(7'o010, 0, 0);
        nv(7'o033, 0, 0);  nv(7'o104, 0, 0);
        nv(7'o033, 0, 0);  nv(7'o121, 0, 0);
        wv(7'o101, 0, 7'o101, 1, 0);
        nv(7'o001, 1, 0);
        nv(7'o033, 1, 0);  nv(7'o131, 1, 0);  nv(7'o067, 1, 23); nv(7'o040, 0, 23);
        nv(7'o033, 0, 23); nv(7'o102, 0, 23);
        eb = 1'b0;
        nv(7'o007, 0, 23);

        do_reset("reset");

        for (int i = 0; i < v.size(); i++) begin
            send(0, v[i].ch);
            chk($sformatf("v%0d_we", i), bus0.mem_we, v[i].we);
            if (v[i].we) begin
                chk($sformatf("v%0d_addr", i), bus0.mem_addr, v[i].addr);
                chk($sformatf("v%0d_data", i), bus0.mem_wdata, v[i].data);
            end
            chk($sformatf("v%0d_x", i),     x0, v[i].x);
            chk($sformatf("v%0d_y", i),     y0, v[i].y);
            chk($sformatf("v%0d_bell", i),  b0, v[i].bell);
            chk($sformatf("v%0d_top", i),   t0, 0);
            chk($sformatf("v%0d_ready", i), bus0.in_ready, 1);
        end

        // Line feed on the bottom row scrolls and blanks physical row 0.
        wq.delete();
        send(0, 7'o012);
        chk("lf_top", t0, 1);
        chk("lf_y", y0, 0);
        chk("lf_x", x0, 0);
        chk("lf_busy", bus0.in_ready, 0);
        wait_idle(0, 200, "lf_idle");
        check_writes("lf", 0, 80);

        // Reverse index at the top, twice, wrapping topline below zero.
        send(0, 7'o033); send(0, 7'o110);
        chk("home_y", y0, 1);
        wq.delete();
        send(0, 7'o033); send(0, 7'o111);
        chk("ri1_top", t0, 0);
        chk("ri1_y", y0, 0);
        chk("ri1_busy", bus0.in_ready, 0);
        wait_idle(0, 200, "ri1_idle");
        check_writes("ri1", 0, 80);
        wq.delete();
        send(0, 7'o033); send(0, 7'o111);
        chk("ri2_top", t0, 23);
        chk("ri2_y", y0, 23);
        wait_idle(0, 200, "ri2_idle");
        check_writes("ri2", 1840, 80);

        // Reverse index away from the top just moves up; rows map mod 24.
        send(0, 7'o033); send(0, 7'o131); send(0, 7'o043); send(0, 7'o040);
        chk("cad_wrap_y", y0, 2);
        send(0, 7'o033); send(0, 7'o111);
        chk("ri3_y", y0, 1);
        chk("ri3_top", t0, 23);
        chk("ri3_ready", bus0.in_ready, 1);

        // Scroll with topline 23 wraps back to 0 and blanks row 23.
        send(0, 7'o033); send(0, 7'o131); send(0, 7'o067); send(0, 7'o040);
        chk("bot_y", y0, 22);
        wq.delete();
        send(0, 7'o012);
        chk("lf2_top", t0, 0);
        chk("lf2_y", y0, 23);
        wait_idle(0, 200, "lf2_idle");
        check_writes("lf2", 1840, 80);

        // Clear to end of screen from (5,10).
        send(0, 7'o033); send(0, 7'o131); send(0, 7'o045); send(0, 7'o052);
        wq.delete();
        send(0, 7'o033); send(0, 7'o112);
        chk("ej_busy", bus0.in_ready, 0);
        chk("ej_x0", x0, 10);
        chk("ej_y0", y0, 5);
        wait_idle(0, 3000, "ej_idle");
        check_writes("ej", 410, 1510);
        chk("ej_x", x0, 10);
        chk("ej_y", y0, 5);

        // Clear to end of line.
        wq.delete();
        send(0, 7'o033); send(0, 7'o113);
        wait_idle(0, 200, "ek_idle");
        check_writes("ek", 410, 70);

        // Autowrap instance: last-column printable wraps and may scroll.
        send(1, 7'o033); send(1, 7'o131); send(1, 7'o047); send(1, 7'o157);
        send(1, 7'o130);
        chk("aw_we", bus1.mem_we, 1);
        chk("aw_addr", bus1.mem_addr, 639);
        chk("aw_data", bus1.mem_wdata, 7'o130);
        chk("aw_x", x1, 0);
        chk("aw_y", y1, 8);
        send(1, 7'o033); send(1, 7'o131); send(1, 7'o067); send(1, 7'o157);
        send(1, 7'o131);
        chk("aw2_addr", bus1.mem_addr, 1919);
        chk("aw2_data", bus1.mem_wdata, 7'o131);
        chk("aw2_x", x1, 0);
        chk("aw2_top", t1, 1);
        chk("aw2_y", y1, 0);
        chk("aw2_busy", bus1.in_ready, 0);
        wait_idle(1, 200, "aw2_idle");

        // Reset in the middle of a screen clear restarts the full clear.
        send(0, 7'o007);
        chk("bell_on", b0, 1);
        send(0, 7'o033); send(0, 7'o112);
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", bus0.in_ready, 0);
        do_reset("midreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
